// File: rtl/mem_pkg.sv
// Shared data-memory definitions: RV32I funct3 size codes, responder states and
// helpers for request legality and lane alignment.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Stores only have signed size codes; loads also have the unsigned variants.
  function automatic logic size_legal(input logic we, input logic [2:0] funct3);
    if (we)
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  // Clears the low address bits a naturally aligned access of this size ignores.
  function automatic logic [1:0] align_lane(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b01:   return {lane[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables; 1-cycle read, no reset.
// Read data holds its value until the next enabled access.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we && be[i])
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the MEM stage: RV32I lane steering over a byte-enable RAM.
// Response LATENCY+1 cycles after accept; holds the response until rsp_ready, one request in flight.
// DMEM_MISALIGN_CHECK_EN: flag misaligned half/word accesses instead of aligning them down.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_t      state;
  logic [2:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_lane;
  logic        cur_err;
  logic        enter_resp;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [1:0]  lane_q;
  logic [31:0] lane_data;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  // With zero wait states the RAM is accessed on the accept edge, straight from the request.
  assign cur_we    = (state == IDLE) ? req_we     : we_q;
  assign cur_f3    = (state == IDLE) ? req_funct3 : f3_q;
  assign cur_addr  = (state == IDLE) ? req_addr   : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata  : wdata_q;
  assign cur_lane  = align_lane(cur_f3, cur_addr[1:0]);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign cur_err = !size_legal(cur_we, cur_f3) || (cur_lane != cur_addr[1:0]);
`else
  assign cur_err = !size_legal(cur_we, cur_f3);
`endif

  assign enter_resp = (LATENCY == 0) ? ((state == IDLE) && req_valid)
                                     : ((state == WAIT) && (cnt == CNT_LAST));
  assign req_ready  = (state == IDLE);

  // Store data is replicated across the word so the byte enables pick the right lanes.
  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin
        ram_be    = 4'b0001 << cur_lane;
        ram_wdata = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        ram_be    = 4'b0011 << cur_lane;
        ram_wdata = {2{cur_wdata[15:0]}};
      end
      2'b10:   ram_be = 4'b1111;
      default: ram_be = 4'b0000;
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp),
    .we    (cur_we && !cur_err),
    .be    (ram_be),
    .addr  (cur_addr[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign unused_addr_bits = ^cur_addr[31:AW+2];

  assign lane_q    = align_lane(f3_q, addr_q[1:0]);
  assign lane_data = ram_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (f3_q)
      F3_B:    rdata = {{24{lane_data[7]}}, lane_data[7:0]};
      F3_BU:   rdata = {24'd0, lane_data[7:0]};
      F3_H:    rdata = {{16{lane_data[15]}}, lane_data[15:0]};
      F3_HU:   rdata = {16'd0, lane_data[15:0]};
      F3_W:    rdata = ram_rdata;
      default: rdata = 32'd0;
    endcase
    if ((state != RESP) || we_q || rsp_err)
      rdata = 32'd0;
  end

  assign rsp_rdata = rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 3'd0;
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= cur_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state     <= RESP;
            cnt       <= 3'd0;
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=1 and LATENCY=3 instances against a byte-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rr0, rv0, re0, rr1, rv1, re1;
  logic [31:0] rd0, rd1;
  logic        c_ready, c_valid, c_err;
  logic [31:0] c_rdata;

  int checks = 0;
  int fails  = 0;
  logic [7:0] mem_m [2][4096];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid && !sel), .req_ready(rr0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready && !sel), .rsp_rdata(rd0), .rsp_err(re0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid && sel), .req_ready(rr1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready && sel), .rsp_rdata(rd1), .rsp_err(re1)
  );

  assign c_ready = sel ? rr1 : rr0;
  assign c_valid = sel ? rv1 : rv0;
  assign c_err   = sel ? re1 : re0;
  assign c_rdata = sel ? rd1 : rd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int  off;
    logic legal;
    off   = int'(a[11:0]) % acc_size(f3);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef DMEM_MISALIGN_CHECK_EN
    return !legal || (off != 0);
`else
    if (off < 0) return 1'b1;
    return !legal;
`endif
  endfunction

  function automatic int eff_addr(input logic [2:0] f3, input logic [31:0] a);
    int a12;
    a12 = int'(a[11:0]);
    return a12 - (a12 % acc_size(f3));
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int ea, sz;
    logic [63:0] vv;
    ea = eff_addr(f3, a);
    sz = acc_size(f3);
    v  = 0;
    for (int i = 0; i < sz; i++) v += longint'(mem_m[d][ea + i]) * (longint'(1) << (8 * i));
    if (f3 == 3'd0 && v >= 128)   v -= 256;
    if (f3 == 3'd1 && v >= 32768) v -= 65536;
    vv = 64'(v);
    return vv[31:0];
  endfunction

  task automatic model_store(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int ea;
    logic [31:0] w;
    ea = eff_addr(f3, a);
    w  = wd;
    for (int i = 0; i < acc_size(f3); i++) begin
      mem_m[d][ea + i] = w[7:0];
      w = w >> 8;
    end
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, input string tag);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          n, lat, d, lmax;
    d      = sel ? 1 : 0;
    lmax   = sel ? 3 : 1;
    exp_er = model_err(we, f3, a);
    exp_rd = (we || exp_er) ? 32'd0 : model_load(d, f3, a);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b0;
    n = 0;
    while (!c_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, " req_ready"}, 32'(c_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!c_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, " latency"}, 32'(lat), 32'(lmax + 1));
    check({tag, " rdata"}, c_rdata, exp_rd);
    check({tag, " err"}, 32'(c_err), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(c_valid), 32'd1);
      check({tag, " hold rdata"}, c_rdata, exp_rd);
      check({tag, " hold err"}, 32'(c_err), 32'(exp_er));
      check({tag, " hold req_ready"}, 32'(c_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " done valid"}, 32'(c_valid), 32'd0);
    check({tag, " done req_ready"}, 32'(c_ready), 32'd1);
    if (we && !exp_er) model_store(d, f3, a, wd);
  endtask

  initial begin
    reset_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'({rv0, rv1}), 32'd0);
    check("reset rsp_rdata1", rd0, 32'd0);
    check("reset rsp_rdata3", rd1, 32'd0);
    check("reset rsp_err", 32'({re0, re1}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset req_ready", 32'({rr0, rr1}), 32'd3);

    // Known contents for the bytes the test touches, in both arrays.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int w = 0; w < 16; w++) xact(1'b1, 3'd2, 32'(4 * w), $urandom, 0, "init sw");
    end
    sel = 1'b0;

    xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "sw 0x10");
    xact(1'b0, 3'd2, 32'h10, 32'd0, 0, "lw 0x10");
    xact(1'b0, 3'd0, 32'h13, 32'd0, 0, "lb 0x13");
    xact(1'b0, 3'd4, 32'h13, 32'd0, 0, "lbu 0x13");
    xact(1'b0, 3'd1, 32'h12, 32'd0, 0, "lh 0x12");
    xact(1'b1, 3'd0, 32'h11, 32'h00000055, 0, "sb 0x11");
    xact(1'b0, 3'd2, 32'h10, 32'd0, 0, "lw after sb");
    check("model after sb", model_load(0, 3'd2, 32'h10), 32'hDEAD55EF);
    xact(1'b1, 3'd1, 32'h12, 32'h00001234, 0, "sh 0x12");
    xact(1'b0, 3'd2, 32'h10, 32'd0, 5, "lw after sh hold");
    check("model after sh", model_load(0, 3'd2, 32'h10), 32'h123455EF);
    xact(1'b0, 3'd2, 32'h12, 32'd0, 0, "lw misaligned 0x12");
    xact(1'b0, 3'd7, 32'h10, 32'd0, 0, "load f3=111");
    xact(1'b1, 3'd5, 32'h10, 32'hFFFFFFFF, 0, "store f3=101");
    xact(1'b0, 3'd2, 32'hFFFFF010, 32'd0, 0, "lw wrapped addr");
    xact(1'b0, 3'd5, 32'h17, 32'd0, 0, "lhu odd 0x17");

    for (int i = 0; i < 40; i++)
      xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)),
           $urandom, int'($urandom_range(0, 2)), "random");

    // Reset during WAIT must drop the store and produce no response.
    sel = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("lat3 in wait", 32'(c_valid), 32'd0);
    reset_n = 1'b0;
    #1;
    check("reset mid-op req_ready", 32'(c_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset mid-op valid", 32'(c_valid), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("after reset no rsp", 32'(c_valid), 32'd0);
    end
    xact(1'b0, 3'd2, 32'h20, 32'd0, 0, "lw 0x20 store dropped");
    xact(1'b1, 3'd0, 32'h22, 32'h000000A5, 0, "lat3 sb 0x22");
    xact(1'b0, 3'd0, 32'h22, 32'd0, 2, "lat3 lb 0x22");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
